// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared loader state type, mode encodings and default word width
package hack_mem_pkg;
    typedef enum logic [2:0] {IDLE, STREAM, FILL, FLUSH, DONE} loader_state_t;
    localparam logic LOAD_STREAM = 1'b0;
    localparam logic LOAD_FILL   = 1'b1;
    localparam int   HACK_REG_W  = 16;
endpackage

// File: rtl/ram_loader.sv
// ram_loader: streams or fills a contiguous RAM address range at one word per cycle
module ram_loader
    import hack_mem_pkg::*;
#(
    parameter int REG_W  = HACK_REG_W,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic [REG_W-1:0]  fill_val_i,
    input  logic              s_valid_i,
    input  logic [REG_W-1:0]  s_data_i,
    output logic              s_ready_o,
    output logic [REG_W-1:0]  ram_in_o,
    output logic              ram_load_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [REG_W-1:0]  fill_q, fill_d, ram_in_q, ram_in_d;
    logic              ram_load_q, ram_load_d;
    logic              issue;

    assign s_ready_o     = state_q == STREAM;
    assign busy_o        = state_q != IDLE;
    assign done_o        = state_q == DONE;
    assign ram_in_o      = ram_in_q;
    assign ram_load_o    = ram_load_q;
    assign ram_address_o = ram_addr_q;
    assign issue         = (state_q == STREAM && s_valid_i) || state_q == FILL;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        fill_d     = fill_q;
        ram_in_d   = ram_in_q;
        ram_addr_d = ram_addr_q;
        ram_load_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                addr_d  = base_i;
                rem_d   = count_i > DEPTH ? DEPTH : count_i;
                fill_d  = fill_val_i;
                state_d = count_i == '0 ? DONE : (mode_i == LOAD_FILL ? FILL : STREAM);
            end
            STREAM, FILL: if (issue) begin
                ram_load_d = 1'b1;
                ram_in_d   = state_q == FILL ? fill_q : s_data_i;
                ram_addr_d = addr_q;
                addr_d     = addr_q + ADDR_W'(1);
                rem_d      = rem_q - (ADDR_W+1)'(1);
                if (rem_q == (ADDR_W+1)'(1)) state_d = FLUSH;
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            fill_q     <= '0;
            ram_in_q   <= '0;
            ram_addr_q <= '0;
            ram_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            fill_q     <= fill_d;
            ram_in_q   <= ram_in_d;
            ram_addr_q <= ram_addr_d;
            ram_load_q <= ram_load_d;
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader with a behavioural 16x64 RAM model
module tb_ram_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [5:0]  base = '0;
    logic [6:0]  count = '0;
    logic [15:0] fill = '0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready_o, ram_load_o, busy_o, done_o;
    logic [15:0] ram_in_o;
    logic [5:0]  ram_address_o;

    logic [15:0] mem [64];
    logic [21:0] sb_q [$];
    logic [21:0] e;
    int n_vec = 0, n_err = 0, n_loads = 0;

    ram_loader #(.REG_W(16), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .base_i(base),
        .count_i(count), .fill_val_i(fill), .s_valid_i(s_valid), .s_data_i(s_data),
        .s_ready_o(s_ready_o), .ram_in_o(ram_in_o), .ram_load_o(ram_load_o),
        .ram_address_o(ram_address_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        return 16'((i + 1) * 16'h1111);
    endfunction

    // RAM model: a write presented in a cycle is committed at that cycle's closing edge
    always @(negedge clk) if (rst_n && ram_load_o) begin
        n_loads++;
        if (sb_q.size() == 0) check("unexpected_load", {26'd0, ram_address_o}, 32'hFFFF_FFFF);
        else begin
            e = sb_q.pop_front();
            check("wr_addr", {26'd0, ram_address_o}, {26'd0, e[21:16]});
            check("wr_data", {16'd0, ram_in_o}, {16'd0, e[15:0]});
        end
        mem[ram_address_o] = ram_in_o;
    end

    task automatic run_job(input string tag, input logic m, input logic [5:0] b,
                           input logic [6:0] c, input logic [15:0] f, input bit toggle);
        int k, done_exp, done_at, done_cnt, loads0, busy_bad, rdy_bad, w;
        k = c > 7'd64 ? 64 : int'(c);
        done_exp = k == 0 ? 1 : (toggle ? 2 * k + 1 : k + 2);
        for (int i = 0; i < k; i++) sb_q.push_back({6'(int'(b) + i), m ? f : word(i)});
        loads0 = n_loads; w = 0; done_at = 0; done_cnt = 0; busy_bad = 0; rdy_bad = 0;
        @(negedge clk);
        start = 1'b1; mode = m; base = b; count = c; fill = f; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= done_exp + 2; n++) begin
            if (n > 1) @(negedge clk);
            s_valid = !m && w < k && (!toggle || n % 2 == 1);
            s_data  = word(w);
            if (s_valid && s_ready_o) w++;
            if (done_o) begin done_cnt++; done_at = n; end
            if (busy_o != (n <= done_exp)) busy_bad++;
            if (m && s_ready_o) rdy_bad++;
        end
        s_valid = 1'b0;
        check({tag, "_done_cycle"}, done_at, done_exp);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_loads"}, n_loads - loads0, k);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_pending"}, sb_q.size(), 0);
        if (m) check({tag, "_s_ready"}, rdy_bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {6'd0, s_ready_o, ram_load_o, busy_o, done_o, ram_address_o, ram_in_o}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {30'd0, busy_o, done_o}, 0);

        run_job("stream3", 1'b0, 6'd5, 7'd3, 16'h0, 1'b0);
        check("ram5", mem[5], 16'h1111);
        check("ram7", mem[7], 16'h3333);
        check("ram4_kept", mem[4], 16'hA004);
        check("ram8_kept", mem[8], 16'hA008);

        run_job("stall4", 1'b0, 6'd0, 7'd4, 16'h0, 1'b1);
        check("ram3", mem[3], 16'h4444);

        run_job("fill_wrap", 1'b1, 6'd62, 7'd4, 16'hFFFF, 1'b0);
        check("ram63", mem[63], 16'hFFFF);
        check("ram1", mem[1], 16'hFFFF);
        check("ram2_kept", mem[2], 16'h3333);

        run_job("zero", 1'b0, 6'd9, 7'd0, 16'h0, 1'b0);
        check("ram9_kept", mem[9], 16'hA009);

        run_job("sat100", 1'b1, 6'd10, 7'd100, 16'hBEEF, 1'b0);
        check("ram9_sat", mem[9], 16'hBEEF);

        // abort a 5-word stream after two accepted words, with a stray start mid-job
        sb_q.push_back({6'd20, word(0)});
        sb_q.push_back({6'd21, word(1)});
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base = 6'd20; count = 7'd5; s_valid = 1'b1; s_data = word(0);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base = 6'd40; count = 7'd7; fill = 16'h5555;
        @(negedge clk);
        start = 1'b0; s_data = word(1);
        @(negedge clk);
        s_data = word(2);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {6'd0, s_ready_o, ram_load_o, busy_o, done_o, ram_address_o, ram_in_o}, 0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_pending", sb_q.size(), 0);
        check("ram22_kept", mem[22], 16'hBEEF);
        check("ram40_kept", mem[40], 16'hBEEF);

        run_job("post_reset", 1'b0, 6'd30, 7'd3, 16'h0, 1'b0);
        check("ram32", mem[32], 16'h3333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_loader.md
# ram_loader

Sequential write engine that sits directly upstream of the Hack `RAM` block and drives its `in`/`load`/`address` inputs. It copies a valid/ready word stream into a contiguous address range, or fills a range with a constant, at one word per cycle. It is used to preload program/data memory and to clear RAM before a run. Completion is reported with a one-cycle `done` pulse.

## Interface
- `REG_W`, 16, data word width; matches the downstream RAM `REG_W`
- `ADDR_W`, 6, RAM address width; the RAM depth is 2^`ADDR_W` (64 by default)

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  job request; sampled only in IDLE
- `mode`  in  1  0 = STREAM (copy from `s_data`), 1 = FILL (write `fill_val`)
- `base`  in  `ADDR_W`  first target address
- `count`  in  `ADDR_W`+1  number of words to write; values above 2^`ADDR_W` saturate to 2^`ADDR_W`
- `fill_val`  in  `REG_W`  constant used in FILL mode
- `s_valid`  in  1  upstream word valid
- `s_data`  in  `REG_W`  upstream word
- `s_ready`  out  1  loader accepts `s_data` this cycle
- `ram_in`  out  `REG_W`  to RAM `in`
- `ram_load`  out  1  to RAM `load`
- `ram_address`  out  `ADDR_W`  to RAM `address`
- `busy`  out  1  a job is in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, STREAM, FILL, FLUSH, DONE.
- Reset (asynchronous, immediate): state = IDLE. All outputs are 0, including `s_ready`, `ram_load`, `ram_in`, `ram_address`, `busy` and `done`. Any pending write is dropped.
- IDLE:
  - `start`=1 latches `base`, the saturated `count`, `mode` and `fill_val`.
  - Next state: DONE if count=0; FILL if `mode`=1; otherwise STREAM.
- STREAM:
  - `s_ready` = 1. It depends on state only, never on `s_valid`.
  - Each edge with `s_valid & s_ready` accepts one word and registers a write of that word to the current address.
  - The address increments modulo 2^`ADDR_W`, so it wraps from 2^`ADDR_W`-1 to 0.
  - The remaining count decrements. On the acceptance that makes remaining = 0, next state = FLUSH.
  - While `s_valid`=0 the loader stalls: no write, `ram_load`=0 in the following cycle.
- FILL:
  - `s_ready` = 0.
  - Every edge registers a write of the latched `fill_val`, with the same address and count rules as STREAM.
  - The last write moves the state to FLUSH.
- FLUSH: the final registered write is presented to the RAM. Next state = DONE.
- DONE: `done`=1 for exactly one cycle. Next state = IDLE.
- `busy` = 1 in STREAM, FILL, FLUSH and DONE; `busy` = 0 in IDLE.
- `start` is ignored whenever state ≠ IDLE.
- Write outputs:
  - `ram_in`, `ram_address` and `ram_load` are registered.
  - `ram_load`=0 in every cycle with no issued write.
  - `ram_in` and `ram_address` hold their last values when no write is issued.

## Timing
- `start` sampled at edge S. The first STREAM/FILL cycle is S+1.
- Write latency: a word accepted or issued at edge N drives `ram_*` during cycle N+1 and is committed by the RAM at edge N+1.
- Throughput: one word per cycle.
- FILL with count = k: `ram_load` is high in cycles S+2..S+k+1, FLUSH occupies cycle S+k+1, and `done` is high in cycle S+k+2.
- STREAM with no stalls: same timing as FILL. Each stalled cycle adds one cycle.
- count = 0: DONE in cycle S+1. `ram_load` never asserts.
- Reset mid-job: outputs clear asynchronously. Words already committed stay in RAM. The next `start` after reset is accepted normally.

## Structure
- Shared package `hack_mem_pkg` holds:
  - the `loader_state_t` enum (IDLE, STREAM, FILL, FLUSH, DONE);
  - the mode constants `LOAD_STREAM`=0 and `LOAD_FILL`=1;
  - the default word width constant (16).
- Single module with no sub-module. The address counter, remaining counter and output registers are all local.

## Test plan
Each bench instantiates `ram_loader` driving `RAM #(16,64)` and reads results back through the RAM.
- Reset -> all outputs 0 and state IDLE; `start` held high during reset has no effect.
- STREAM, `base`=5, `count`=3, words 0x1111/0x2222/0x3333 with `s_valid` held high -> RAM[5]=0x1111, RAM[6]=0x2222, RAM[7]=0x3333; `done` high only in cycle S+5; RAM[4] and RAM[8] unchanged.
- STREAM, `base`=0, `count`=4, `s_valid` toggling 1,0,1,0,... -> exactly 4 `ram_load` pulses; RAM[0..3] hold the 4 words in order; `done` is delayed by the 3 stall cycles.
- FILL, `base`=62, `count`=4, `fill_val`=0xFFFF -> addresses 62, 63, 0, 1 written with 0xFFFF (wrap); RAM[2]=old value; `s_ready` stays 0 throughout.
- `count`=0 -> `done` in cycle S+1, no `ram_load`. `count`=100 -> saturates to 64 writes.
- Reset asserted after 2 accepted words of a 5-word STREAM -> `ram_load` drops immediately; a `start` issued mid-job is ignored; a new job after reset completes correctly.
